// File: rtl/lvalue_checks_seq.sv
// DEPTH x WIDTH word store with full/slice/bit writes and a scan FSM that XOR-reduces it.
// Optional macro LVALUE_CLEAR_EN enables wr_mode 3 (clear entry); otherwise mode 3 is rejected.
module lvalue_checks_seq #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int SLICE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_assign,
    input  logic [1:0]       wr_mode,
    input  logic [7:0]       wr_idx,
    input  logic [7:0]       wr_off,
    input  logic [WIDTH-1:0] in_data,
    input  logic             scan_start,
    output logic             busy,
    output logic             scan_done,
    output logic             dummy_out,
    output logic             err_out
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_L = 9'(DEPTH);
    localparam logic [8:0] WIDTH_L = 9'(WIDTH);
    localparam logic [8:0] SLICE_L = 9'(SLICE_W);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    ptr_q;
    logic             acc_q;
    logic             busy_q;
    logic             done_q;
    logic             dummy_q;
    logic             err_q;

    logic             idx_ok;
    logic [AW-1:0]    widx;
    logic [8:0]       slice_end;
    logic [WIDTH-1:0] old_word;
    logic [WIDTH-1:0] smask;
    logic [WIDTH-1:0] sdata;
    logic [WIDTH-1:0] bmask;
    logic             wr_ok;
    logic             wr_req;
    logic             wr_en_d;
    logic             err_d;
    logic [WIDTH-1:0] word_d;

    always_comb begin
        idx_ok    = {1'b0, wr_idx} < DEPTH_L;
        widx      = wr_idx[AW-1:0];
        old_word  = mem_q[widx];
        // 9-bit sum so an offset near 255 cannot wrap back into range
        slice_end = {1'b0, wr_off} + SLICE_L;
        smask     = WIDTH'({SLICE_W{1'b1}}) << wr_off;
        sdata     = WIDTH'(in_data[SLICE_W-1:0]) << wr_off;
        bmask     = WIDTH'(1) << wr_off;
        wr_ok     = 1'b0;
        word_d    = old_word;
        case (wr_mode)
            2'd0: begin
                wr_ok  = idx_ok;
                word_d = in_data;
            end
            2'd1: begin
                wr_ok  = idx_ok && (slice_end <= WIDTH_L);
                word_d = (old_word & ~smask) | (sdata & smask);
            end
            2'd2: begin
                wr_ok  = idx_ok && ({1'b0, wr_off} < WIDTH_L);
                word_d = (old_word & ~bmask) | ({WIDTH{in_data[0]}} & bmask);
            end
            2'd3: begin
`ifdef LVALUE_CLEAR_EN
                wr_ok  = idx_ok;
                word_d = '0;
`else
                wr_ok  = 1'b0;
`endif
            end
            default: wr_ok = 1'b0;
        endcase
        wr_req  = enable_assign && (state_q == IDLE);
        wr_en_d = wr_req && wr_ok;
        err_d   = wr_req && !wr_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i[AW-1:0]] <= '0;
            end
            state_q <= IDLE;
            ptr_q   <= '0;
            acc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dummy_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q  <= err_d;
            done_q <= 1'b0;
            if (wr_en_d) begin
                mem_q[widx] <= word_d;
            end
            case (state_q)
                IDLE: begin
                    if (scan_start) begin
                        state_q <= SCAN;
                        ptr_q   <= '0;
                        acc_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    acc_q <= acc_q ^ (^mem_q[ptr_q]);
                    ptr_q <= ptr_q + 1'b1;
                    // result is registered on the last SCAN edge so it lands in the DONE cycle
                    if (ptr_q == LAST) begin
                        state_q <= DONE;
                        dummy_q <= acc_q ^ (^mem_q[ptr_q]);
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign scan_done = done_q;
    assign dummy_out = dummy_q;
    assign err_out   = err_q;

endmodule

// File: tb/tb_lvalue_checks_seq.sv
// Bench for lvalue_checks_seq: directed cases plus random writes/scans against an array model.
module tb_lvalue_checks_seq;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 8;
    localparam int SLICE_W = 4;

    logic             clk;
    logic             rst;
    logic             enable_assign;
    logic [1:0]       wr_mode;
    logic [7:0]       wr_idx;
    logic [7:0]       wr_off;
    logic [WIDTH-1:0] in_data;
    logic             scan_start;
    logic             busy;
    logic             scan_done;
    logic             dummy_out;
    logic             err_out;

    lvalue_checks_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SLICE_W(SLICE_W)) dut (
        .clk(clk), .rst(rst), .enable_assign(enable_assign), .wr_mode(wr_mode),
        .wr_idx(wr_idx), .wr_off(wr_off), .in_data(in_data), .scan_start(scan_start),
        .busy(busy), .scan_done(scan_done), .dummy_out(dummy_out), .err_out(err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] mem_m [DEPTH];
    bit               dummy_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        dummy_m = 1'b0;
    endtask

    task automatic mdl_write(input int mode, input int idx, input int off,
                             input logic [WIDTH-1:0] data, output bit err);
        err = 1'b0;
        if (idx >= DEPTH) begin
            err = 1'b1;
        end else if (mode == 0) begin
            mem_m[idx] = data;
        end else if (mode == 1) begin
            if (off + SLICE_W <= WIDTH)
                for (int i = 0; i < SLICE_W; i++) mem_m[idx][off + i] = data[i];
            else
                err = 1'b1;
        end else if (mode == 2) begin
            if (off < WIDTH) mem_m[idx][off] = data[0];
            else err = 1'b1;
        end else begin
`ifdef LVALUE_CLEAR_EN
            mem_m[idx] = '0;
`else
            err = 1'b1;
`endif
        end
    endtask

    function automatic bit mdl_parity();
        int ones = 0;
        for (int i = 0; i < DEPTH; i++) ones += $countones(mem_m[i]);
        return ones[0];
    endfunction

    task automatic drive_wr(input int mode, input int idx, input int off, input logic [WIDTH-1:0] data);
        enable_assign = 1'b1;
        wr_mode       = mode[1:0];
        wr_idx        = idx[7:0];
        wr_off        = off[7:0];
        in_data       = data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        mdl_clear();
        check("rst_busy", busy, 0);
        check("rst_scan_done", scan_done, 0);
        check("rst_dummy", dummy_out, 0);
        check("rst_err", err_out, 0);
    endtask

    task automatic wr(input int mode, input int idx, input int off, input logic [WIDTH-1:0] data);
        bit e;
        drive_wr(mode, idx, off, data);
        mdl_write(mode, idx, off, data, e);
        step();
        enable_assign = 1'b0;
        check("wr_err", err_out, e);
        check("wr_busy", busy, 0);
        step();
        check("err_pulse_end", err_out, 0);
    endtask

    // with_wr: write at the same edge as scan_start; wr_during: write while scanning; rst_at: cycle k to reset (0 = none)
    task automatic scan(input bit with_wr, input int mode, input int idx, input int off,
                        input logic [WIDTH-1:0] data, input bit wr_during, input int rst_at);
        bit e = 1'b0;
        bit exp;
        scan_start = 1'b1;
        if (with_wr) begin
            drive_wr(mode, idx, off, data);
            mdl_write(mode, idx, off, data, e);
        end
        exp = mdl_parity();
        step();
        scan_start    = 1'b0;
        enable_assign = 1'b0;
        for (int k = 1; k <= DEPTH + 1; k++) begin
            check("scan_busy", busy, 1);
            check("scan_done", scan_done, (k == DEPTH + 1) ? 1 : 0);
            check("scan_dummy", dummy_out, (k == DEPTH + 1) ? exp : dummy_m);
            check("scan_err", err_out, (k == 1) ? e : 0);
            if (rst_at != 0 && k == rst_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                mdl_clear();
                for (int j = 0; j < DEPTH + 2; j++) begin
                    check("abort_busy", busy, 0);
                    check("abort_done", scan_done, 0);
                    check("abort_dummy", dummy_out, 0);
                    step();
                end
                return;
            end
            if (wr_during && k == 2)
                drive_wr($urandom_range(0, 3), $urandom_range(0, DEPTH - 1),
                         $urandom_range(0, WIDTH + 1), WIDTH'($urandom));
            else
                enable_assign = 1'b0;
            if (k == DEPTH + 1) dummy_m = exp;
            step();
        end
        enable_assign = 1'b0;
        check("post_busy", busy, 0);
        check("post_done", scan_done, 0);
        check("post_err", err_out, 0);
        check("post_dummy", dummy_out, dummy_m);
    endtask

    initial begin
        rst = 1'b0; enable_assign = 1'b0; wr_mode = '0; wr_idx = '0;
        wr_off = '0; in_data = '0; scan_start = 1'b0;
        mdl_clear();
        do_reset();

        wr(0, 2, 0, 16'h0001);
        scan(0, 0, 0, 0, '0, 0, 0);
        check("full_word_dummy", dummy_out, 1);

        wr(1, 5, 12, 16'h000F);
        wr(1, 5, 13, 16'h000F);
        wr(1, 5, 200, 16'h000F);
        wr(1, 5, 253, 16'h000F);
        scan(0, 0, 0, 0, '0, 0, 0);

        wr(2, 0, 15, 16'h0001);
        wr(2, 0, 16, 16'h0001);
        wr(0, 8, 0, 16'h1234);
        wr(2, 255, 0, 16'h0001);
        scan(0, 0, 0, 0, '0, 0, 0);

        scan(1, 0, 7, 0, 16'h0003, 0, 0);
        scan(0, 0, 0, 0, '0, 1, 0);
        scan(0, 0, 0, 0, '0, 0, 0);

        wr(0, 3, 0, 16'h0007);
        scan(0, 0, 0, 0, '0, 0, 4);
        scan(0, 0, 0, 0, '0, 0, 0);
        check("after_abort_dummy", dummy_out, 0);

        wr(0, 2, 0, 16'h0001);
        wr(3, 2, 0, 16'h0000);
        wr(3, 9, 0, 16'h0000);
        scan(0, 0, 0, 0, '0, 0, 0);

        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 5) == 0)
                scan($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, DEPTH + 1),
                     $urandom_range(0, WIDTH + 1), WIDTH'($urandom), $urandom_range(0, 1), 0);
            else
                wr($urandom_range(0, 3), $urandom_range(0, DEPTH + 1),
                   $urandom_range(0, WIDTH + 1), WIDTH'($urandom));
        end
        scan(0, 0, 0, 0, '0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
